// File: rtl/tf_delay_line.sv
// Stallable twiddle-factor/modulus delay line with a runtime-selectable tap (0..MAX_DEPTH).
// Define TF_DLY_DATA_RST_EN to also clear the stage data registers on reset.
module tf_delay_line #(
  parameter int D_WIDTH       = 64,
  parameter int LANES         = 16,
  parameter int MAX_DEPTH     = 8,
  parameter int DEFAULT_DEPTH = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             flush,
  input  logic [$clog2(MAX_DEPTH+1)-1:0]   depth_sel,
  input  logic                             in_valid,
  input  logic [LANES*D_WIDTH-1:0]         tf_in,
  input  logic [D_WIDTH-1:0]               modulus_in,
  output logic                             out_valid,
  output logic [LANES*D_WIDTH-1:0]         tf_out,
  output logic [D_WIDTH-1:0]               modulus_out,
  output logic                             busy,
  output logic [$clog2(MAX_DEPTH+1)-1:0]   depth_cfg
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int TF_W    = LANES * D_WIDTH;

  logic advance;
  logic capture;
  logic [DEPTH_W-1:0] depth_reg;
  logic [DEPTH_W-1:0] depth_next;

  // Index 0 of each bus is the pipeline input; index i is stage i.
  logic [MAX_DEPTH:0] v_bus;
  logic [TF_W-1:0]    tf_bus  [0:MAX_DEPTH];
  logic [D_WIDTH-1:0] mod_bus [0:MAX_DEPTH];

  assign advance = en & ~flush;
  assign capture = in_valid & advance;

  assign v_bus[0]   = in_valid;
  assign tf_bus[0]  = tf_in;
  assign mod_bus[0] = modulus_in;

  genvar gi;
  generate
    for (gi = 1; gi <= MAX_DEPTH; gi++) begin : g_stage
      logic               v_reg;
      logic [TF_W-1:0]    tf_reg;
      logic [D_WIDTH-1:0] mod_reg;

      // Invalid entries shift too, so a bubble keeps its slot in the timeline.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_reg <= 1'b0;
        end else if (flush) begin
          v_reg <= 1'b0;
        end else if (en) begin
          v_reg <= v_bus[gi-1];
        end
      end

`ifdef TF_DLY_DATA_RST_EN
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          tf_reg  <= '0;
          mod_reg <= '0;
        end else if (advance) begin
          tf_reg  <= tf_bus[gi-1];
          mod_reg <= mod_bus[gi-1];
        end
      end
`else
      always_ff @(posedge clk) begin
        if (advance) begin
          tf_reg  <= tf_bus[gi-1];
          mod_reg <= mod_bus[gi-1];
        end
      end
`endif

      assign v_bus[gi]   = v_reg;
      assign tf_bus[gi]  = tf_reg;
      assign mod_bus[gi] = mod_reg;
    end
  endgenerate

  assign busy = |v_bus[MAX_DEPTH:1];

  assign depth_next = (depth_sel > DEPTH_W'(MAX_DEPTH)) ? DEPTH_W'(MAX_DEPTH) : depth_sel;

  // The tap may only move when nothing is in flight and nothing enters this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth_reg <= DEPTH_W'(DEFAULT_DEPTH);
    end else if (!busy && !capture) begin
      depth_reg <= depth_next;
    end
  end

  assign depth_cfg = depth_reg;

  always_comb begin
    out_valid   = capture;
    tf_out      = tf_in;
    modulus_out = modulus_in;
    for (int i = 1; i <= MAX_DEPTH; i++) begin
      if (depth_reg == DEPTH_W'(i)) begin
        out_valid   = v_bus[i];
        tf_out      = tf_bus[i];
        modulus_out = mod_bus[i];
      end
    end
  end

endmodule

// File: tb/tb_tf_delay_line.sv
// Self-checking bench for tf_delay_line: scoreboard of expected entries plus
// hand-written sequences for reset, stall, flush, depth change, bypass and clamp.
module tb_tf_delay_line;

  localparam int DW = 64;
  localparam int LN = 16;
  localparam int MD = 8;
  localparam int TW = DW * LN;
  localparam int SW = $clog2(MD + 1);

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          en         = 1'b0;
  logic          flush      = 1'b0;
  logic [SW-1:0] depth_sel  = SW'(3);
  logic          in_valid   = 1'b0;
  logic [TW-1:0] tf_in      = '0;
  logic [DW-1:0] modulus_in = '0;
  logic          out_valid;
  logic [TW-1:0] tf_out;
  logic [DW-1:0] modulus_out;
  logic          busy;
  logic [SW-1:0] depth_cfg;

  tf_delay_line #(
    .D_WIDTH(DW), .LANES(LN), .MAX_DEPTH(MD), .DEFAULT_DEPTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .depth_sel(depth_sel),
    .in_valid(in_valid), .tf_in(tf_in), .modulus_in(modulus_in),
    .out_valid(out_valid), .tf_out(tf_out), .modulus_out(modulus_out),
    .busy(busy), .depth_cfg(depth_cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tf;
    logic [DW-1:0] md;
    int            tgt;
  } exp_t;

  typedef struct {
    logic v;
    logic e;
    logic f;
    int   seed;
    logic exp_ov;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   en_count = 0;

  // Enabled edges seen so far; an entry is due when this reaches its target.
  always @(posedge clk) if (en) en_count <= en_count + 1;

  function automatic logic [TW-1:0] gen_tf(input int seed);
    logic [TW-1:0] r;
    for (int k = 0; k < LN; k++) r[k*DW +: DW] = {32'(seed), 32'(k + 1)};
    return r;
  endfunction

  function automatic logic [DW-1:0] gen_mod(input int seed);
    return 64'h3FFF_FFFF_FFFF_FFFF - 64'(seed) * 64'h0000_0001_0001_0001;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic chk_tf(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int k = LN - 1; k >= 0; k--) if (act[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: lane %0d got %h expected %h (t=%0t)", name, bad,
               act[bad*DW +: DW], exp[bad*DW +: DW], $time);
    end else begin
      $display("ok   %s: lane0 %h", name, act[DW-1:0]);
    end
  endtask

  task automatic set_in(input logic v, input logic e, input logic f, input int seed, input int dly);
    exp_t x;
    in_valid   = v;
    en         = e;
    flush      = f;
    tf_in      = gen_tf(seed);
    modulus_in = gen_mod(seed);
    if (f) begin
      sb_q.delete();
    end else if (v && e) begin
      x.tf  = gen_tf(seed);
      x.md  = gen_mod(seed);
      x.tgt = en_count + dly;
      sb_q.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic e, input logic f, input int seed, input int dly);
    set_in(v, e, f, seed, dly);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) idle(1);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  // Scoreboard: an entry is consumed on the enabled cycle in which it is presented.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && en && !flush) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("sb_latency", 64'(en_count), 64'(e.tgt));
          chk("sb_modulus", modulus_out, e.md);
          chk_tf("sb_tf", tf_out, e.tf);
        end
      end else if (sb_q.size() > 0 && sb_q[0].tgt <= en_count) begin
        checks++;
        errors++;
        $display("FAIL missed_out: out_valid=0 expected 1 (t=%0t)", $time);
        e = sb_q.pop_front();
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 50, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 51, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 52, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 53, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 54, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 55, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 56, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 57, 1'b1};

    // Reset default and basic depth-3 latency
    set_in(1'b0, 1'b1, 1'b0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_depth", 64'(depth_cfg), 64'd3);
    step(1'b1, 1'b1, 1'b0, 0, 3);
    chk("cap_busy", 64'(busy), 64'd1);
    idle(1);
    chk("d3_ov_early", 64'(out_valid), 64'd0);
    idle(1);
    chk("d3_ov", 64'(out_valid), 64'd1);
    chk("d3_mod", modulus_out, 64'h3FFF_FFFF_FFFF_FFFF);
    chk_tf("d3_tf", tf_out, gen_tf(0));
    idle(1);
    chk("d3_ov_after", 64'(out_valid), 64'd0);
    wait_idle(12);

    // Stall: in_valid is ignored while en=0, output holds while stalled
    step(1'b1, 1'b1, 1'b0, 1, 3);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 99, 0);
      chk("stall_ov", 64'(out_valid), 64'd0);
    end
    chk("stall_busy", 64'(busy), 64'd1);
    idle(1);
    chk("stall_ov_out", 64'(out_valid), 64'd1);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    chk("stall_hold_ov", 64'(out_valid), 64'd1);
    chk("stall_hold_mod", modulus_out, gen_mod(1));
    wait_idle(12);

    // Flush: with en=1, and with en=0; then capture right after a flush
    step(1'b1, 1'b1, 1'b0, 2, 3);
    step(1'b1, 1'b1, 1'b1, 3, 0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ov", 64'(out_valid), 64'd0);
    step(1'b1, 1'b1, 1'b0, 4, 3);
    step(1'b1, 1'b1, 1'b0, 5, 3);
    step(1'b1, 1'b1, 1'b1, 6, 0);
    chk("flush2_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("flush_quiet_ov", 64'(out_valid), 64'd0);
    end
    step(1'b1, 1'b1, 1'b0, 12, 3);
    step(1'b0, 1'b0, 1'b1, 0, 0);
    chk("flush_noen_busy", 64'(busy), 64'd0);
    step(1'b1, 1'b1, 1'b0, 11, 3);
    idle(2);
    chk("post_flush_ov", 64'(out_valid), 64'd1);
    chk("post_flush_mod", modulus_out, gen_mod(11));
    wait_idle(12);

    // Depth change is deferred until the pipe drains
    step(1'b1, 1'b1, 1'b0, 20, 3);
    depth_sel = SW'(5);
    idle(1);
    chk("dchg_hold", 64'(depth_cfg), 64'd3);
    wait_idle(12);
    chk("dchg_still3", 64'(depth_cfg), 64'd3);
    idle(1);
    chk("dchg_5", 64'(depth_cfg), 64'd5);
    step(1'b1, 1'b1, 1'b0, 21, 5);
    idle(3);
    chk("d5_ov_early", 64'(out_valid), 64'd0);
    idle(1);
    chk("d5_ov", 64'(out_valid), 64'd1);
    chk_tf("d5_tf", tf_out, gen_tf(21));
    wait_idle(12);

    // Bypass (depth 0), table-driven
    depth_sel = SW'(0);
    idle(1);
    chk("byp_depth", 64'(depth_cfg), 64'd0);
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].v, vecs[i].e, vecs[i].f, vecs[i].seed, 0);
      #1;
      chk("byp_ov", 64'(out_valid), 64'(vecs[i].exp_ov));
      chk("byp_mod", modulus_out, gen_mod(vecs[i].seed));
      chk_tf("byp_tf", tf_out, gen_tf(vecs[i].seed));
      tick();
    end

    // Clamp: 15 -> MAX_DEPTH
    depth_sel = SW'(15);
    wait_idle(12);
    idle(1);
    chk("clamp_depth", 64'(depth_cfg), 64'd8);
    step(1'b1, 1'b1, 1'b0, 30, 8);
    idle(6);
    chk("d8_ov_early", 64'(out_valid), 64'd0);
    idle(1);
    chk("d8_ov", 64'(out_valid), 64'd1);
    chk("d8_mod", modulus_out, gen_mod(30));
    wait_idle(12);

    // Reset mid-operation overrides a capture and restores the default depth
    depth_sel = SW'(3);
    step(1'b1, 1'b1, 1'b0, 40, 8);
    step(1'b1, 1'b1, 1'b0, 41, 8);
    step(1'b1, 1'b1, 1'b0, 42, 8);
    in_valid = 1'b1;
    en       = 1'b1;
    flush    = 1'b0;
    rst_n    = 1'b0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 0, 0);
    #1;
    chk("mrst_ov", 64'(out_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_depth", 64'(depth_cfg), 64'd3);
`ifdef TF_DLY_DATA_RST_EN
    chk("mrst_mod_zero", modulus_out, 64'd0);
    chk_tf("mrst_tf_zero", tf_out, '0);
`endif
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("mrst_quiet_ov", 64'(out_valid), 64'd0);
    end

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
